// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for the 5-stage pipeline (load-use, MUL/DIV, MEM wait, branch).
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
`default_nettype none

module hazard_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ars1_id_i,
  input  logic [4:0]       ars2_id_i,
  input  logic [4:0]       ard_id_ex_i,
  input  logic             memread_id_ex_i,
  input  logic             muldiv_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             mem_req_ex_mem_i,
  input  logic             mem_ready_i,
  output logic             stall_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             stall_ex_mem_o,
  output logic             flush_if_id_o,
  output logic             bubble_id_ex_o,
  output logic             bubble_ex_mem_o,
  output logic             bubble_mem_wb_o,
  output logic             md_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;
  localparam bit         MD_EN   = (MULDIV_LATENCY > 1);
  localparam logic [3:0] MD_INIT = MD_EN ? 4'(MULDIV_LATENCY - 2) : 4'd0;

  logic [0:0] state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_busy_q, md_busy_d;

  logic mem_freeze, md_issue, md_occ, load_use;

  assign mem_freeze = mem_req_ex_mem_i && !mem_ready_i;
  assign md_issue   = (state_q == RUN) && muldiv_ex_i && MD_EN;
  // The MD_WAIT cycle that sees the counter at zero is the op's last EX cycle and is not stalled.
  assign md_occ     = md_issue || ((state_q == MD_WAIT) && (md_cnt_q != 4'd0));
  assign load_use   = memread_id_ex_i && (ard_id_ex_i != 5'd0) &&
                      ((ard_id_ex_i == ars1_id_i) || (ard_id_ex_i == ars2_id_i));

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (md_issue && !mem_freeze) begin
          state_d  = MD_WAIT;
          md_cnt_d = MD_INIT;
        end
      end
      default: begin
        if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
        if ((md_cnt_q == 4'd0) && !mem_freeze) state_d = RUN;
      end
    endcase
    md_busy_d = (state_d == MD_WAIT) && (md_cnt_d != 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_cnt_q  <= 4'd0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  always_comb begin
    stall_pc_o      = 1'b0;
    stall_if_id_o   = 1'b0;
    stall_id_ex_o   = 1'b0;
    stall_ex_mem_o  = 1'b0;
    flush_if_id_o   = 1'b0;
    bubble_id_ex_o  = 1'b0;
    bubble_ex_mem_o = 1'b0;
    bubble_mem_wb_o = 1'b0;
    if (!rst_n) begin
      stall_pc_o = 1'b0;
    end else if (mem_freeze) begin
      stall_pc_o      = 1'b1;
      stall_if_id_o   = 1'b1;
      stall_id_ex_o   = 1'b1;
      stall_ex_mem_o  = 1'b1;
      bubble_mem_wb_o = 1'b1;
    end else if (md_occ) begin
      stall_pc_o      = 1'b1;
      stall_if_id_o   = 1'b1;
      stall_id_ex_o   = 1'b1;
      bubble_ex_mem_o = 1'b1;
    end else if (branch_taken_ex_i) begin
      flush_if_id_o  = 1'b1;
      bubble_id_ex_o = 1'b1;
    end else if (load_use) begin
      stall_pc_o     = 1'b1;
      stall_if_id_o  = 1'b1;
      bubble_id_ex_o = 1'b1;
    end
  end

  assign md_busy_o = md_busy_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_pc_o)    stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_if_id_o) flush_count_q  <= flush_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

`default_nettype wire
